// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode/indirect sequencer.
package fetch_pkg;

  // Common-bus source select codes.
  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  // Sequencer states; T0..T3 are the classic timing steps.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    EXEC = 3'd5
  } state_t;

  // Register-reference / IO opcode: its I bit selects IO vs register ops,
  // so it never means an indirect operand fetch.
  localparam logic [2:0] OPC_REG_IO = 3'd7;

  // Width of the sequence counter.
  localparam int SC_BITS = 4;

  // True when the decoded instruction needs the indirect address cycle.
  function automatic logic takes_indirect(input logic [2:0] opcode, input logic i_bit);
    takes_indirect = i_bit && (opcode != OPC_REG_IO);
  endfunction

endpackage

// File: rtl/RippleCarryIncrementer.sv
// Plain ripple-carry +1 incrementer; carry_out flags the wrap from all-ones.
module RippleCarryIncrementer #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] value,
  output logic [BITS-1:0] result,
  output logic            carry_out
);

  logic [BITS:0] carry_s;

  assign carry_s[0] = 1'b1;

  // One half-adder per bit, carry rippling upward.
  for (genvar i = 0; i < BITS; i++) begin : g_bit
    assign result[i]    = value[i] ^ carry_s[i];
    assign carry_s[i+1] = value[i] & carry_s[i];
  end

  assign carry_out = carry_s[BITS];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/indirect control sequencer of the basic computer.
// Strobes and bus select are decoded from state and inputs; opcode, I bit,
// sequence counter and the execute start pulse are registered.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int WORD_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run_in,
  input  logic [WORD_BITS-1:0] ir_in,
  input  logic                 mem_ready_in,
  input  logic                 exec_done_in,
  output logic [2:0]           bus_sel_out,
  output logic                 ar_load_out,
  output logic                 pc_increment_out,
  output logic                 ir_load_out,
  output logic                 mem_read_out,
  output logic [2:0]           opcode_out,
  output logic                 indirect_out,
  output logic                 exec_start_out,
  output logic [SC_BITS-1:0]   sc_out,
  output logic                 busy_out
);

  state_t             state_r;
  state_t             next_state_s;
  bus_sel_t           bus_sel_s;
  logic               ar_load_s;
  logic               pc_increment_s;
  logic               ir_load_s;
  logic               mem_read_s;
  logic [2:0]         opcode_r;
  logic               indirect_r;
  logic               exec_start_r;
  logic [SC_BITS-1:0] sc_r;
  logic [SC_BITS-1:0] sc_inc_s;
  logic               sc_carry_s;
  logic [SC_BITS-1:0] sc_next_s;
  logic [2:0]         ir_opcode_s;
  logic               ir_i_bit_s;

  // The address field travels over the bus, not through this block.
  logic unused_addr_s;
  assign unused_addr_s = ^ir_in[ADDR_BITS-1:0];

  assign ir_opcode_s = ir_in[WORD_BITS-2 -: 3];
  assign ir_i_bit_s  = ir_in[WORD_BITS-1];

  RippleCarryIncrementer #(
    .BITS(SC_BITS)
  ) u_sc_inc (
    .value    (sc_r),
    .result   (sc_inc_s),
    .carry_out(sc_carry_s)
  );

  // Saturate: a carry out means sc_r is already all ones, so keep it.
  assign sc_next_s = sc_carry_s ? sc_r : sc_inc_s;

  // Decode strobes, bus select and next state from the current state.
  always_comb begin
    next_state_s   = state_r;
    bus_sel_s      = BUS_NONE;
    ar_load_s      = 1'b0;
    pc_increment_s = 1'b0;
    ir_load_s      = 1'b0;
    mem_read_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_in) begin
          next_state_s = T0;
        end else begin
          next_state_s = IDLE;
        end
      end
      T0: begin
        bus_sel_s    = BUS_PC;
        ar_load_s    = 1'b1;
        next_state_s = T1;
      end
      T1: begin
        bus_sel_s  = BUS_MEM;
        mem_read_s = 1'b1;
        if (mem_ready_in) begin
          ir_load_s      = 1'b1;
          pc_increment_s = 1'b1;
          next_state_s   = T2;
        end else begin
          next_state_s = T1;
        end
      end
      T2: begin
        bus_sel_s = BUS_IR;
        ar_load_s = 1'b1;
        if (takes_indirect(ir_opcode_s, ir_i_bit_s)) begin
          next_state_s = T3;
        end else begin
          next_state_s = EXEC;
        end
      end
      T3: begin
        bus_sel_s  = BUS_MEM;
        mem_read_s = 1'b1;
        if (mem_ready_in) begin
          ar_load_s    = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = T3;
        end
      end
      EXEC: begin
        if (exec_done_in) begin
          if (run_in) begin
            next_state_s = T0;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = EXEC;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, decoded-field latch, sequence counter and execute start pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      opcode_r     <= 3'd0;
      indirect_r   <= 1'b0;
      sc_r         <= {SC_BITS{1'b0}};
      exec_start_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      exec_start_r <= (next_state_s == EXEC) && (state_r != EXEC);
      if (state_r == T2) begin
        opcode_r   <= ir_opcode_s;
        indirect_r <= ir_i_bit_s;
      end else begin
        opcode_r   <= opcode_r;
        indirect_r <= indirect_r;
      end
      if ((next_state_s == T0) || (next_state_s == IDLE)) begin
        sc_r <= {SC_BITS{1'b0}};
      end else begin
        sc_r <= sc_next_s;
      end
    end
  end

  // While held in reset every strobe is quiet, whatever the state register says.
  assign bus_sel_out      = reset_n ? bus_sel_s : BUS_NONE;
  assign ar_load_out      = reset_n & ar_load_s;
  assign pc_increment_out = reset_n & pc_increment_s;
  assign ir_load_out      = reset_n & ir_load_s;
  assign mem_read_out     = reset_n & mem_read_s;
  assign exec_start_out   = reset_n & exec_start_r;
  assign busy_out         = reset_n & (state_r != IDLE);
  assign opcode_out       = opcode_r;
  assign indirect_out     = indirect_r;
  assign sc_out           = sc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each directed step pushes the
// expected output vector; a negedge monitor pops and compares it.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic        run_in;
  logic [15:0] ir_in;
  logic        mem_ready_in;
  logic        exec_done_in;
  logic [2:0]  bus_sel_out;
  logic        ar_load_out;
  logic        pc_increment_out;
  logic        ir_load_out;
  logic        mem_read_out;
  logic [2:0]  opcode_out;
  logic        indirect_out;
  logic        exec_start_out;
  logic [3:0]  sc_out;
  logic        busy_out;

  fetch_sequencer #(
    .ADDR_BITS(12),
    .WORD_BITS(16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .run_in          (run_in),
    .ir_in           (ir_in),
    .mem_ready_in    (mem_ready_in),
    .exec_done_in    (exec_done_in),
    .bus_sel_out     (bus_sel_out),
    .ar_load_out     (ar_load_out),
    .pc_increment_out(pc_increment_out),
    .ir_load_out     (ir_load_out),
    .mem_read_out    (mem_read_out),
    .opcode_out      (opcode_out),
    .indirect_out    (indirect_out),
    .exec_start_out  (exec_start_out),
    .sc_out          (sc_out),
    .busy_out        (busy_out)
  );

  // Strobe groups: {bus_sel[2:0], ar_load, pc_inc, ir_load, mem_read, busy}.
  localparam logic [7:0] S_RST  = {3'd0, 5'b00000};
  localparam logic [7:0] S_IDLE = {3'd0, 5'b00000};
  localparam logic [7:0] S_T0   = {3'd2, 5'b10001};
  localparam logic [7:0] S_T1W  = {3'd7, 5'b00011};
  localparam logic [7:0] S_T1R  = {3'd7, 5'b01111};
  localparam logic [7:0] S_T2   = {3'd5, 5'b10001};
  localparam logic [7:0] S_T3W  = {3'd7, 5'b00011};
  localparam logic [7:0] S_T3R  = {3'd7, 5'b10011};
  localparam logic [7:0] S_EXEC = {3'd0, 5'b00001};

  localparam logic [15:0] IR_DIRECT   = 16'h2123;
  localparam logic [15:0] IR_INDIRECT = 16'hA123;
  localparam logic [15:0] IR_REGIO    = 16'hF800;

  string       name_q[$];
  logic [16:0] exp_q[$];
  string       cur_name;
  logic [16:0] cur_exp;
  logic [16:0] actual;
  int          checks;
  int          passed;
  int          fails;

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "time limit expired");
  end

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cur_name = name_q.pop_front();
      cur_exp  = exp_q.pop_front();
      actual   = {bus_sel_out, ar_load_out, pc_increment_out, ir_load_out,
                  mem_read_out, busy_out, exec_start_out, sc_out, opcode_out,
                  indirect_out};
      checks++;
      if (actual === cur_exp) begin
        passed++;
      end else begin
        fails++;
        $display("FAIL %s: got %h required %h (bus,ar,pc,ir,mr,busy,start,sc,opc,ind)",
                 cur_name, actual, cur_exp);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic rst, input logic run, input logic mr, input logic done,
                      input logic [15:0] ir, input logic [7:0] s, input logic es,
                      input logic [3:0] sc, input logic [2:0] opc, input logic ind,
                      input string nm);
    reset_n      = rst;
    run_in       = run;
    mem_ready_in = mr;
    exec_done_in = done;
    ir_in        = ir;
    name_q.push_back(nm);
    exp_q.push_back({s, es, sc, opc, ind});
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    reset_n = 1'b0;
    run_in = 1'b0;
    mem_ready_in = 1'b0;
    exec_done_in = 1'b0;
    ir_in = 16'h0000;
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, S_RST, 1'b0, 4'd0, 3'd0, 1'b0, "reset");

    // Direct instruction, zero wait, immediate done.
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_IDLE, 1'b0, 4'd0, 3'd0, 1'b0, "d_idle");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T0,   1'b0, 4'd0, 3'd0, 1'b0, "d_t0");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T1R,  1'b0, 4'd1, 3'd0, 1'b0, "d_t1");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T2,   1'b0, 4'd2, 3'd0, 1'b0, "d_t2");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_EXEC, 1'b1, 4'd3, 3'd2, 1'b0, "d_exec");

    // Indirect instruction: T3 taken, start pulse in the fifth cycle.
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_INDIRECT, S_T0,   1'b0, 4'd0, 3'd2, 1'b0, "i_t0");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_INDIRECT, S_T1R,  1'b0, 4'd1, 3'd2, 1'b0, "i_t1");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_INDIRECT, S_T2,   1'b0, 4'd2, 3'd2, 1'b0, "i_t2");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_INDIRECT, S_T3R,  1'b0, 4'd3, 3'd2, 1'b1, "i_t3");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_INDIRECT, S_EXEC, 1'b1, 4'd4, 3'd2, 1'b1, "i_exec");

    // Register/IO opcode with I=1 skips T3.
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_REGIO, S_T0,   1'b0, 4'd0, 3'd2, 1'b1, "r_t0");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_REGIO, S_T1R,  1'b0, 4'd1, 3'd2, 1'b1, "r_t1");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_REGIO, S_T2,   1'b0, 4'd2, 3'd2, 1'b1, "r_t2");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_REGIO, S_EXEC, 1'b1, 4'd3, 3'd7, 1'b1, "r_exec");

    // Memory not ready for three cycles (T0 and two T1 cycles), then slow done.
    step(1'b1, 1'b1, 1'b0, 1'b0, IR_DIRECT, S_T0,  1'b0, 4'd0, 3'd7, 1'b1, "w_t0");
    step(1'b1, 1'b1, 1'b0, 1'b0, IR_DIRECT, S_T1W, 1'b0, 4'd1, 3'd7, 1'b1, "w_t1a");
    step(1'b1, 1'b1, 1'b0, 1'b0, IR_DIRECT, S_T1W, 1'b0, 4'd2, 3'd7, 1'b1, "w_t1b");
    step(1'b1, 1'b1, 1'b1, 1'b0, IR_DIRECT, S_T1R, 1'b0, 4'd3, 3'd7, 1'b1, "w_t1r");
    step(1'b1, 1'b1, 1'b1, 1'b0, IR_DIRECT, S_T2,  1'b0, 4'd4, 3'd7, 1'b1, "w_t2");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, IR_DIRECT, S_EXEC, (i == 0) ? 1'b1 : 1'b0,
           (i < 10) ? 4'(5 + i) : 4'd15, 3'd2, 1'b0, "w_exec_hold");
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, IR_DIRECT, S_EXEC, 1'b0, 4'd15, 3'd2, 1'b0, "w_exec_done");
    step(1'b1, 1'b0, 1'b1, 1'b1, IR_DIRECT, S_IDLE, 1'b0, 4'd0,  3'd2, 1'b0, "w_idle");

    // run_in dropped mid-instruction, then reset while waiting in T3.
    step(1'b1, 1'b1, 1'b1, 1'b0, IR_INDIRECT, S_IDLE, 1'b0, 4'd0, 3'd2, 1'b0, "x_idle");
    step(1'b1, 1'b0, 1'b1, 1'b0, IR_INDIRECT, S_T0,   1'b0, 4'd0, 3'd2, 1'b0, "x_t0");
    step(1'b1, 1'b0, 1'b1, 1'b0, IR_INDIRECT, S_T1R,  1'b0, 4'd1, 3'd2, 1'b0, "x_t1");
    step(1'b1, 1'b0, 1'b0, 1'b0, IR_INDIRECT, S_T2,   1'b0, 4'd2, 3'd2, 1'b0, "x_t2");
    step(1'b1, 1'b0, 1'b0, 1'b0, IR_INDIRECT, S_T3W,  1'b0, 4'd3, 3'd2, 1'b1, "x_t3a");
    step(1'b1, 1'b0, 1'b0, 1'b0, IR_INDIRECT, S_T3W,  1'b0, 4'd4, 3'd2, 1'b1, "x_t3b");
    step(1'b0, 1'b0, 1'b0, 1'b0, IR_INDIRECT, S_RST,  1'b0, 4'd5, 3'd2, 1'b1, "x_rst_t3");
    step(1'b1, 1'b0, 1'b0, 1'b0, IR_DIRECT,   S_IDLE, 1'b0, 4'd0, 3'd0, 1'b0, "x_after_rst");

    // Restart after reset.
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_IDLE, 1'b0, 4'd0, 3'd0, 1'b0, "z_idle");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T0,   1'b0, 4'd0, 3'd0, 1'b0, "z_t0");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T1R,  1'b0, 4'd1, 3'd0, 1'b0, "z_t1");
    step(1'b1, 1'b1, 1'b1, 1'b1, IR_DIRECT, S_T2,   1'b0, 4'd2, 3'd0, 1'b0, "z_t2");
    step(1'b1, 1'b0, 1'b1, 1'b1, IR_DIRECT, S_EXEC, 1'b1, 4'd3, 3'd2, 1'b0, "z_exec");
    step(1'b1, 1'b0, 1'b1, 1'b1, IR_DIRECT, S_IDLE, 1'b0, 4'd0, 3'd2, 1'b0, "z_idle_end");

    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
